inst_fetch_bridge: RTL and testbench

Fetch-side responder for the IF stage: consumes the fetch address and chip-enable produced by the PC register, and issues one word read per PC on the SRAM-like instruction bus. It returns the instruction plus a stall request that holds the PC until the word is available. It also owns the fixed kseg0/kseg1 address mapping and the fetch address-error check. It sits between the IF-stage PC register and the instruction cache / bus arbiter.

---
 rtl/inst_fetch_bridge_pkg.sv | 24 ++
 rtl/inst_addr_map.sv | 20 ++
 rtl/inst_fetch_bridge.sv | 135 +++++++++++++
 tb/tb_inst_fetch_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge and the address mapper.
//   - fetch FSM state encoding
//   - bus transfer size code for a full word
//   - kseg0/kseg1 segment selectors (virtual address bits [31:29])
package inst_fetch_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } fetch_state_e;

  localparam logic [1:0] InstSizeWord = 2'b10;

  localparam logic [2:0] SegKseg0 = 3'b100;
  localparam logic [2:0] SegKseg1 = 3'b101;

  // kseg0 and kseg1 are unmapped windows onto the low 512 MiB of physical memory.
  function automatic logic is_unmapped_seg(input logic [2:0] seg);
    return (seg == SegKseg0) || (seg == SegKseg1);
  endfunction

endpackage

// File: rtl/inst_addr_map.sv
// Combinational virtual-to-physical address mapper.
// Ports:
//   vaddr_i  in  32  virtual address
//   paddr_o  out 32  physical address (kseg0/kseg1 have their top 3 bits cleared,
//                    every other segment passes through unchanged)
module inst_addr_map
  import inst_fetch_bridge_pkg::*;
(
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o
);

  always_comb begin
    paddr_o = vaddr_i;
    if (is_unmapped_seg(vaddr_i[31:29])) begin
      paddr_o = {3'b000, vaddr_i[28:0]};
    end
  end

endmodule

// File: rtl/inst_fetch_bridge.sv
// IF-stage fetch responder. Takes the PC and fetch enable from the PC register,
// performs one word read per PC on the SRAM-like instruction bus and returns the
// instruction plus a stall request that holds the PC until the word is ready.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   ce, pcF              fetch enable and virtual fetch address
//   cpu_stall, flushF    back-pressure from later stages, fetch redirect
//   instrF, instr_valid  fetched instruction and its valid flag
//   adelF                fetch address error, valid alongside instr_valid
//   stallreq_if          hold the PC, instruction not yet available
//   inst_req/wr/size/addr  bus request channel
//   inst_addr_ok, inst_data_ok, inst_rdata  bus response channel
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter logic [31:0] RESET_INST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pcF,
  input  logic        cpu_stall,
  input  logic        flushF,
  output logic [31:0] instrF,
  output logic        instr_valid,
  output logic        adelF,
  output logic        stallreq_if,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  addr_q, addr_d;
  logic         adel_q, adel_d;
  // Set when the outstanding request was flushed; its data must be dropped.
  logic         discard_q, discard_d;
  logic [31:0]  paddr;

  inst_addr_map u_addr_map (
    .vaddr_i (pcF),
    .paddr_o (paddr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      instr_q   <= RESET_INST;
      addr_q    <= 32'h0;
      adel_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      adel_q    <= adel_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    adel_d    = adel_q;
    discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        if (ce && !flushF) begin
          if (pcF[1:0] != 2'b00) begin
            // Misaligned fetch: report the error without touching the bus.
            state_d = StDone;
            adel_d  = 1'b1;
            instr_d = RESET_INST;
          end else begin
            state_d   = StReq;
            addr_d    = paddr;
            adel_d    = 1'b0;
            discard_d = 1'b0;
          end
        end
      end
      StReq: begin
        // The request stays up until accepted; a flush only marks it for discard.
        if (flushF) begin
          discard_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          if (discard_q || flushF) begin
            state_d   = StIdle;
            instr_d   = RESET_INST;
            discard_d = 1'b0;
          end else begin
            state_d = StDone;
            instr_d = inst_rdata;
            adel_d  = 1'b0;
          end
        end else if (flushF) begin
          discard_d = 1'b1;
        end
      end
      StDone: begin
        if (!cpu_stall || flushF) begin
          state_d = StIdle;
          adel_d  = 1'b0;
          if (flushF) begin
            instr_d = RESET_INST;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign instrF      = instr_q;
  assign instr_valid = (state_q == StDone);
  assign adelF       = adel_q;
  assign inst_req    = (state_q == StReq);
  assign inst_addr   = addr_q;
  assign inst_wr     = 1'b0;
  assign inst_size   = InstSizeWord;
  // Gated by reset so the stall request is low while the block is held in reset.
  assign stallreq_if = rst & ce & (state_q != StDone);

endmodule

// File: tb/tb_inst_fetch_bridge.sv
module tb_inst_fetch_bridge;

  localparam logic [31:0] ResetInst = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pcF;
  logic        cpu_stall;
  logic        flushF;
  logic [31:0] instrF;
  logic        instr_valid;
  logic        adelF;
  logic        stallreq_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(
    .RESET_INST (ResetInst)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .pcF          (pcF),
    .cpu_stall    (cpu_stall),
    .flushF       (flushF),
    .instrF       (instrF),
    .instr_valid  (instr_valid),
    .adelF        (adelF),
    .stallreq_if  (stallreq_if),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference mapping from the segment address ranges.
  function automatic logic [31:0] ref_map(input logic [31:0] v);
    if (v >= 32'h8000_0000 && v <= 32'h9FFF_FFFF) return v - 32'h8000_0000;
    if (v >= 32'hA000_0000 && v <= 32'hBFFF_FFFF) return v - 32'hA000_0000;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch. Entered and left with the DUT idle.
  // fl_req / fl_wait: cycle index within REQ / WAIT carrying a flush pulse, -1 for none.
  task automatic fetch(input logic [31:0] pc, input int ad, input int dd,
                       input logic [31:0] word, input int fl_req, input int fl_wait,
                       input int stall_n, input bit fl_done);
    bit drop;
    drop = (fl_req >= 0) || (fl_wait >= 0);
    ce = 1'b1; pcF = pc; flushF = 1'b0; cpu_stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    #1;
    check("idle_stallreq", stallreq_if, 1);
    check("idle_req", inst_req, 0);
    tick();
    if (pc[1:0] != 2'b00) begin
      check("adel_req", inst_req, 0);
      check("adel_valid", instr_valid, 1);
      check("adel_flag", adelF, 1);
      check("adel_instr", instrF, ResetInst);
      check("adel_stallreq", stallreq_if, 0);
      ce = 1'b0;
      tick();
      check("adel_exit_valid", instr_valid, 0);
      return;
    end
    for (int k = 0; k <= ad; k++) begin
      check("req_req", inst_req, 1);
      check("req_addr", inst_addr, ref_map(pc));
      check("req_stallreq", stallreq_if, 1);
      check("req_valid", instr_valid, 0);
      inst_addr_ok = (k == ad);
      inst_data_ok = (k < ad) ? 1'($urandom_range(0, 1)) : 1'b0;
      inst_rdata   = $urandom;
      flushF       = (k == fl_req);
      tick();
    end
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; flushF = 1'b0;
    for (int k = 0; k <= dd; k++) begin
      check("wait_req", inst_req, 0);
      check("wait_stallreq", stallreq_if, 1);
      check("wait_valid", instr_valid, 0);
      inst_data_ok = (k == dd);
      inst_rdata   = (k == dd) ? word : $urandom;
      flushF       = (k == fl_wait);
      tick();
    end
    inst_data_ok = 1'b0; flushF = 1'b0;
    if (drop) begin
      check("drop_valid", instr_valid, 0);
      check("drop_req", inst_req, 0);
      check("drop_instr", instrF, ResetInst);
      return;
    end
    check("done_valid", instr_valid, 1);
    check("done_instr", instrF, word);
    check("done_adel", adelF, 0);
    check("done_stallreq", stallreq_if, 0);
    check("done_req", inst_req, 0);
    for (int s = 0; s < stall_n; s++) begin
      cpu_stall    = 1'b1;
      inst_rdata   = $urandom;
      inst_data_ok = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instrF, word);
    end
    inst_data_ok = 1'b0;
    cpu_stall = fl_done;
    flushF    = fl_done;
    ce        = 1'b0;
    tick();
    flushF = 1'b0; cpu_stall = 1'b0;
    check("exit_valid", instr_valid, 0);
    check("exit_stallreq", stallreq_if, 0);
    if (fl_done) check("exit_flush_instr", instrF, ResetInst);
  endtask

  initial begin
    logic [31:0] pc;
    int ad, dd, fr, fw, r;

    rst = 1'b0; ce = 1'b0; pcF = 32'h0; cpu_stall = 1'b0; flushF = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instrF, ResetInst);
    check("rst_valid", instr_valid, 0);
    check("rst_adel", adelF, 0);
    check("rst_req", inst_req, 0);
    check("rst_addr", inst_addr, 0);
    check("rst_stallreq", stallreq_if, 0);
    check("const_wr", inst_wr, 0);
    check("const_size", inst_size, 2'b10);
    rst = 1'b1;
    tick();
    check("idle_no_ce_stallreq", stallreq_if, 0);

    // Minimum latency kseg1 fetch.
    fetch(32'hBFC0_0000, 0, 0, 32'h2408_0001, -1, -1, 0, 1'b0);
    // Bus wait states.
    fetch(32'hBFC0_0004, 3, 2, 32'h1234_5678, -1, -1, 0, 1'b0);
    // Flush while waiting for data, then the next PC is fetched.
    fetch(32'hBFC0_0008, 0, 2, 32'hDEAD_BEEF, -1, 0, 0, 1'b0);
    fetch(32'h8000_0100, 1, 1, 32'hCAFE_0001, -1, -1, 0, 1'b0);
    // Flush coinciding with data_ok, and flush during REQ.
    fetch(32'h8000_0104, 0, 1, 32'hDEAD_BEEF, -1, 1, 0, 1'b0);
    fetch(32'h0040_0000, 2, 0, 32'hDEAD_BEEF, 1, -1, 0, 1'b0);
    // Back-pressure in DONE with changing bus data.
    fetch(32'h9000_0010, 0, 0, 32'h0F0F_A5A5, -1, -1, 5, 1'b0);
    // Flush while stalled in DONE.
    fetch(32'h9000_0014, 0, 0, 32'h1111_2222, -1, -1, 2, 1'b1);
    // Misaligned fetch.
    fetch(32'h8000_0002, 0, 0, 32'h0, -1, -1, 0, 1'b0);
    fetch(32'hA000_0020, 0, 0, 32'h3333_4444, -1, -1, 0, 1'b0);

    // Reset asserted while in WAIT.
    ce = 1'b1; pcF = 32'hBFC0_0100;
    tick();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_req", inst_req, 0);
    check("midrst_addr", inst_addr, 0);
    check("midrst_valid", instr_valid, 0);
    check("midrst_adel", adelF, 0);
    check("midrst_instr", instrF, ResetInst);
    check("midrst_stallreq", stallreq_if, 0);
    tick();
    rst = 1'b1;
    fetch(32'hBFC0_0100, 0, 0, 32'h5555_6666, -1, -1, 0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       pc = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFC);
        1:       pc = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFC);
        default: pc = $urandom & 32'hFFFF_FFFC;
      endcase
      if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fr = -1; fw = -1;
      r = $urandom_range(0, 5);
      if (r == 0) fr = $urandom_range(0, ad);
      if (r == 1) fw = $urandom_range(0, dd);
      fetch(pc, ad, dd, $urandom, fr, fw, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) begin
        ce = 1'b0;
        tick();
        check("gap_stallreq", stallreq_if, 0);
        check("gap_req", inst_req, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
